msg_arbiter_2to1: RTL and testbench

MSG_ARBITER_2TO1 -- requirements
Module: msg_arbiter_2to1

---
 rtl/msg_arbiter_2to1_pkg.sv | 20 ++
 rtl/calc_redun.sv | 28 ++
 rtl/msg_arbiter_2to1.sv | 177 +++++++++++++++++
 tb/tb_msg_arbiter_2to1.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_arbiter_2to1_pkg.sv
// Shared channel widths, arbiter state encoding and helpers for the 2:1 message arbiter.
package msg_arbiter_2to1_pkg;

    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 16;
    localparam int NS_REDUN_SIZE   = 4;

    typedef enum logic [2:0] {
        NS_IDLE    = 3'd0,
        NS_IN_ACK  = 3'd1,
        NS_OUT_ARM = 3'd2,
        NS_OUT_REQ = 3'd3,
        NS_OUT_REL = 3'd4
    } arb_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/calc_redun.sv
// Redundancy generator: bit i of the {src,dst,dat} word is XOR-folded into redundancy bit (i mod RSZ).
module calc_redun
    import msg_arbiter_2to1_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE
) (
    input  logic [ASZ-1:0] src_i,
    input  logic [ASZ-1:0] dst_i,
    input  logic [DSZ-1:0] dat_i,
    output logic [RSZ-1:0] red_o
);

    localparam int unsigned MW = 2 * ASZ + DSZ;

    logic [MW-1:0] msg;

    assign msg = {src_i, dst_i, dat_i};

    always_comb begin
        red_o = '0;
        for (int unsigned i = 0; i < MW; i++) begin
            red_o[i % RSZ] = red_o[i % RSZ] ^ msg[i];
        end
    end

endmodule

// File: rtl/msg_arbiter_2to1.sv
// Round-robin 2:1 store-and-forward message arbiter with four-phase handshakes on
// both sides and redundancy check that drops corrupted messages.
module msg_arbiter_2to1
    import msg_arbiter_2to1_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack_out,
    input  logic [ASZ-1:0] i1_src,
    input  logic [ASZ-1:0] i1_dst,
    input  logic [DSZ-1:0] i1_dat,
    input  logic [RSZ-1:0] i1_red,
    input  logic           i1_req,
    output logic           i1_ack_out,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req_out,
    input  logic           o0_ack,
    output logic           grant,
    output logic [3:0]     err_cnt,
    output logic           err
);

    arb_state_e     state_q, state_d;
    logic           grant_q, grant_d;
    logic           last_q, last_d;
    logic [ASZ-1:0] src_q, src_d;
    logic [ASZ-1:0] dst_q, dst_d;
    logic [DSZ-1:0] dat_q, dat_d;
    logic [RSZ-1:0] red_q, red_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           oreq_q, oreq_d;
    logic [3:0]     err_cnt_q, err_cnt_d;
    logic           err_q, err_d;

    logic           req0_new, req1_new, pick, gnt_req;
    logic [RSZ-1:0] red_calc;

    calc_redun #(
        .ASZ (ASZ),
        .DSZ (DSZ),
        .RSZ (RSZ)
    ) u_calc_redun (
        .src_i (src_q),
        .dst_i (dst_q),
        .dat_i (dat_q),
        .red_o (red_calc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= NS_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            src_q     <= '0;
            dst_q     <= '0;
            dat_q     <= '0;
            red_q     <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            oreq_q    <= 1'b0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            dat_q     <= dat_d;
            red_q     <= red_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            oreq_q    <= oreq_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        src_d     = src_q;
        dst_d     = dst_q;
        dat_d     = dat_q;
        red_d     = red_q;
        ack0_d    = ack0_q;
        ack1_d    = ack1_q;
        oreq_d    = oreq_q;
        err_cnt_d = err_cnt_q;
        err_d     = err_q;

        req0_new = i0_req & ~ack0_q;
        req1_new = i1_req & ~ack1_q;
        // On a tie serve the side not served last; otherwise the only requester.
        pick     = (req0_new & req1_new) ? ~last_q : req1_new;
        gnt_req  = grant_q ? i1_req : i0_req;

        unique case (state_q)
            NS_IDLE: begin
                if (req0_new | req1_new) begin
                    grant_d = pick;
                    src_d   = pick ? i1_src : i0_src;
                    dst_d   = pick ? i1_dst : i0_dst;
                    dat_d   = pick ? i1_dat : i0_dat;
                    red_d   = pick ? i1_red : i0_red;
                    ack0_d  = ~pick;
                    ack1_d  = pick;
                    state_d = NS_IN_ACK;
                end
            end
            NS_IN_ACK: begin
                if (!gnt_req) begin
                    ack0_d = 1'b0;
                    ack1_d = 1'b0;
                    if (red_calc != red_q) begin
                        err_cnt_d = sat_inc4(err_cnt_q);
                        err_d     = 1'b1;
                        last_d    = grant_q;
                        state_d   = NS_IDLE;
                    end else if (!o0_ack) begin
                        // Downstream already idle: pass straight through OUT_ARM so
                        // o0_req_out follows the input release by one cycle.
                        oreq_d  = 1'b1;
                        state_d = NS_OUT_REQ;
                    end else begin
                        state_d = NS_OUT_ARM;
                    end
                end
            end
            NS_OUT_ARM: begin
                if (!o0_ack) begin
                    oreq_d  = 1'b1;
                    state_d = NS_OUT_REQ;
                end
            end
            NS_OUT_REQ: begin
                if (o0_ack) begin
                    oreq_d  = 1'b0;
                    state_d = NS_OUT_REL;
                end
            end
            NS_OUT_REL: begin
                if (!o0_ack) begin
                    last_d  = grant_q;
                    state_d = NS_IDLE;
                end
            end
            default: state_d = NS_IDLE;
        endcase
    end

    assign i0_ack_out = ack0_q;
    assign i1_ack_out = ack1_q;
    assign o0_req_out = oreq_q;
    assign o0_src     = src_q;
    assign o0_dst     = dst_q;
    assign o0_dat     = dat_q;
    assign o0_red     = red_q;
    assign grant      = grant_q;
    assign err_cnt    = err_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_msg_arbiter_2to1.sv
// Bench for msg_arbiter_2to1: directed requester scenarios, an auto-echo downstream
// responder, and a transaction scoreboard checked on every output handshake.
module tb_msg_arbiter_2to1;
    import msg_arbiter_2to1_pkg::*;

    localparam int AW = NS_ADDRESS_SIZE;
    localparam int DW = NS_DATA_SIZE;
    localparam int RW = NS_REDUN_SIZE;

    logic          clk, reset;
    logic [AW-1:0] i0_src, i0_dst, i1_src, i1_dst, o0_src, o0_dst;
    logic [DW-1:0] i0_dat, i1_dat, o0_dat;
    logic [RW-1:0] i0_red, i1_red, o0_red;
    logic          i0_req, i1_req, i0_ack_out, i1_ack_out;
    logic          o0_req_out, o0_ack, grant, err;
    logic [3:0]    err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic          g;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [DW-1:0] dat;
        logic [RW-1:0] red;
    } msg_t;

    msg_t exp_q[$];
    logic gseq[$];
    bit   ack_hold  = 0;
    bit   ack_force = 0;

    msg_arbiter_2to1 #(.ASZ(AW), .DSZ(DW), .RSZ(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .i0_src     (i0_src),
        .i0_dst     (i0_dst),
        .i0_dat     (i0_dat),
        .i0_red     (i0_red),
        .i0_req     (i0_req),
        .i0_ack_out (i0_ack_out),
        .i1_src     (i1_src),
        .i1_dst     (i1_dst),
        .i1_dat     (i1_dat),
        .i1_red     (i1_red),
        .i1_req     (i1_req),
        .i1_ack_out (i1_ack_out),
        .o0_src     (o0_src),
        .o0_dst     (o0_dst),
        .o0_dat     (o0_dat),
        .o0_red     (o0_red),
        .o0_req_out (o0_req_out),
        .o0_ack     (o0_ack),
        .grant      (grant),
        .err_cnt    (err_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Redundancy from its definition: XOR of all RW-bit chunks of {src,dst,dat}.
    function automatic logic [RW-1:0] good_red(input logic [AW-1:0] s, input logic [AW-1:0] d,
                                               input logic [DW-1:0] x);
        logic [2*AW+DW-1:0] w;
        logic [RW-1:0]      r;
        w = {s, d, x};
        r = '0;
        while (w != '0) begin
            r = r ^ w[RW-1:0];
            w = w >> RW;
        end
        return r;
    endfunction

    function automatic msg_t mk(input logic g, input logic [AW-1:0] s, input logic [AW-1:0] d,
                                input logic [DW-1:0] x);
        msg_t m;
        m.g = g; m.src = s; m.dst = d; m.dat = x; m.red = good_red(s, d, x);
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic ack_of(input bit side);
        return side ? i1_ack_out : i0_ack_out;
    endfunction

    // Downstream responder: echoes o0_req_out onto o0_ack after 2 cycles unless held.
    int rcnt = 0;
    always @(posedge clk) begin
        #1;
        if (ack_hold) begin
            o0_ack = ack_force;
            rcnt   = 0;
        end else if (o0_req_out != o0_ack) begin
            rcnt++;
            if (rcnt >= 2) begin
                o0_ack = o0_req_out;
                rcnt   = 0;
            end
        end else begin
            rcnt = 0;
        end
    end

    // Compare process: every output request is matched against the scoreboard.
    logic                    prev_req = 1'b0;
    logic                    prev_ack = 1'b0;
    logic [2*AW+DW+RW-1:0]   hold_fields;
    msg_t                    cur;
    always @(negedge clk) begin
        if (!reset) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            check("ack_exclusive", 64'(i0_ack_out & i1_ack_out), 64'(0));
            if (o0_req_out && !prev_req) begin
                check("req_rise_with_ack_low", 64'(prev_ack), 64'(0));
                gseq.push_back(grant);
                hold_fields = {o0_src, o0_dst, o0_dat, o0_red};
                if (exp_q.size() == 0) begin
                    timeout("unexpected_output_message");
                end else begin
                    cur = exp_q.pop_front();
                    check("out_grant", 64'(grant), 64'(cur.g));
                    check("out_src", 64'(o0_src), 64'(cur.src));
                    check("out_dst", 64'(o0_dst), 64'(cur.dst));
                    check("out_dat", 64'(o0_dat), 64'(cur.dat));
                    check("out_red", 64'(o0_red), 64'(cur.red));
                end
            end else if (o0_req_out) begin
                check("out_stable", 64'({o0_src, o0_dst, o0_dat, o0_red}), 64'(hold_fields));
            end
            prev_req = o0_req_out;
            prev_ack = o0_ack;
        end
    end

    task automatic send(input bit side, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [DW-1:0] x, input logic [RW-1:0] r,
                        output int lat_up, output int lat_dn);
        if (side) begin
            i1_src = s; i1_dst = d; i1_dat = x; i1_red = r; i1_req = 1'b1;
        end else begin
            i0_src = s; i0_dst = d; i0_dat = x; i0_red = r; i0_req = 1'b1;
        end
        lat_up = 0;
        do begin
            @(posedge clk); #1;
            lat_up++;
        end while (!ack_of(side) && lat_up < 300);
        if (!ack_of(side)) timeout("input_ack_rise");
        if (side) i1_req = 1'b0; else i0_req = 1'b0;
        lat_dn = 0;
        do begin
            @(posedge clk); #1;
            lat_dn++;
        end while (ack_of(side) && lat_dn < 300);
        if (ack_of(side)) timeout("input_ack_fall");
    endtask

    task automatic wait_quiet();
        int quiet = 0;
        int n     = 0;
        while (quiet < 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (!o0_req_out && !o0_ack && !i0_ack_out && !i1_ack_out) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) timeout("quiet");
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_o0_req", 64'(o0_req_out), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int up, dn, k, p0, p1;
        logic last, pk;
        reset = 1'b0;
        i0_src = '0; i0_dst = '0; i0_dat = '0; i0_red = '0; i0_req = 1'b0;
        i1_src = '0; i1_dst = '0; i1_dat = '0; i1_red = '0; i1_req = 1'b0;
        o0_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_acks", 64'({i0_ack_out, i1_ack_out, o0_req_out}), 64'(0));
        check("reset_grant", 64'(grant), 64'(0));
        check("reset_err", 64'({err_cnt, err}), 64'(0));
        check("reset_buffer", 64'({o0_src, o0_dst, o0_dat, o0_red}), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        // Single requester, dat=5
        exp_q.push_back(mk(1'b0, 8'h01, 8'h02, 16'd5));
        send(1'b0, 8'h01, 8'h02, 16'd5, good_red(8'h01, 8'h02, 16'd5), up, dn);
        check("s1_ack_latency", 64'(up), 64'(1));
        check("s1_oreq_latency", 64'(dn), 64'(1));
        check("s1_oreq_high", 64'(o0_req_out), 64'(1));
        check("s1_dat", 64'(o0_dat), 64'(5));
        check("s1_red_literal", 64'(o0_red), 64'(6));
        wait_quiet();
        check("s1_err", 64'(err), 64'(0));

        // Corrupted redundancy from i1 is acknowledged but dropped
        do_reset();
        send(1'b1, 8'h03, 8'h04, 16'd9, good_red(8'h03, 8'h04, 16'd9) ^ 4'h1, up, dn);
        check("s3_ack_latency", 64'(up), 64'(1));
        repeat (6) begin
            @(posedge clk); #1;
            check("s3_no_oreq", 64'(o0_req_out), 64'(0));
        end
        check("s3_err_cnt", 64'(err_cnt), 64'(1));
        check("s3_err", 64'(err), 64'(1));

        // 17 bad messages: counter saturates at 15
        do_reset();
        for (k = 1; k <= 17; k++) begin
            send(k[0], 8'(k), 8'h40, 16'(k * 3), good_red(8'(k), 8'h40, 16'(k * 3)) ^ 4'h1, up, dn);
            check("s4_err_cnt", 64'(err_cnt), 64'((k > 15) ? 15 : k));
            check("s4_err", 64'(err), 64'(1));
        end
        check("s4_no_oreq", 64'(o0_req_out), 64'(0));

        // Both sides contend for 4 messages each; round-robin order from the rule
        do_reset();
        gseq.delete();
        last = 1'b1; p0 = 0; p1 = 0;
        while (p0 < 4 || p1 < 4) begin
            if (p0 < 4 && p1 < 4) pk = ~last;
            else pk = (p1 < 4);
            if (pk) begin p1++; exp_q.push_back(mk(1'b1, 8'h11, 8'h20, 16'(p1))); end
            else begin p0++; exp_q.push_back(mk(1'b0, 8'h10, 8'h20, 16'(p0))); end
            last = pk;
        end
        fork
            begin
                int u0, d0;
                for (int n = 1; n <= 4; n++)
                    send(1'b0, 8'h10, 8'h20, 16'(n), good_red(8'h10, 8'h20, 16'(n)), u0, d0);
            end
            begin
                int u1, d1;
                for (int n = 1; n <= 4; n++)
                    send(1'b1, 8'h11, 8'h20, 16'(n), good_red(8'h11, 8'h20, 16'(n)), u1, d1);
            end
        join
        wait_quiet();
        check("s2_count", 64'(gseq.size()), 64'(8));
        if (gseq.size() >= 4) begin
            check("s2_grant0", 64'(gseq[0]), 64'(0));
            check("s2_grant1", 64'(gseq[1]), 64'(1));
            check("s2_grant2", 64'(gseq[2]), 64'(0));
            check("s2_grant3", 64'(gseq[3]), 64'(1));
        end
        check("s2_all_delivered", 64'(exp_q.size()), 64'(0));

        // Stale o0_ack on entry to OUT_ARM
        ack_hold = 1; ack_force = 1;
        @(posedge clk); #2;
        exp_q.push_back(mk(1'b0, 8'h55, 8'h66, 16'h1234));
        send(1'b0, 8'h55, 8'h66, 16'h1234, good_red(8'h55, 8'h66, 16'h1234), up, dn);
        repeat (4) begin
            @(posedge clk); #2;
            check("s5_held_low", 64'(o0_req_out), 64'(0));
        end
        ack_force = 0;
        k = 0;
        while (o0_ack && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (o0_ack) timeout("s5_ack_release");
        check("s5_still_low", 64'(o0_req_out), 64'(0));
        @(negedge clk);
        check("s5_rise_next", 64'(o0_req_out), 64'(1));
        ack_hold = 0;
        wait_quiet();

        // Reset during OUT_REQ with i1 still requesting
        ack_hold = 1; ack_force = 0;
        exp_q.push_back(mk(1'b0, 8'h30, 8'h31, 16'h0BAD));
        send(1'b0, 8'h30, 8'h31, 16'h0BAD, good_red(8'h30, 8'h31, 16'h0BAD), up, dn);
        i1_src = 8'h41; i1_dst = 8'h42; i1_dat = 16'h7777; i1_red = good_red(8'h41, 8'h42, 16'h7777);
        i1_req = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("s6_in_out_req", 64'(o0_req_out), 64'(1));
            check("s6_i1_ignored", 64'(i1_ack_out), 64'(0));
        end
        reset = 1'b0;
        #1;
        check("s6_rst_oreq", 64'(o0_req_out), 64'(0));
        check("s6_rst_acks", 64'({i0_ack_out, i1_ack_out}), 64'(0));
        check("s6_rst_grant", 64'(grant), 64'(0));
        exp_q.push_back(mk(1'b1, 8'h41, 8'h42, 16'h7777));
        @(posedge clk); #1;
        reset = 1'b1;
        ack_hold = 0;
        @(posedge clk); #1;
        check("s6_i1_granted", 64'(i1_ack_out), 64'(1));
        check("s6_grant", 64'(grant), 64'(1));
        i1_req = 1'b0;
        k = 0;
        while (i1_ack_out && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (i1_ack_out) timeout("s6_i1_release");
        wait_quiet();

        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
